// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Shares the single RegisterFile write port between two writeback sources.
//   req0 (single-cycle ALU) is preferred; req1 (multi-cycle unit) is forced to
//   win after losing STARVE_LIMIT consecutive contested cycles. The granted
//   write is registered so the RegisterFile commits it on the following edge.
//   A pending-write scoreboard (busy_mask) is kept for RAW hazard stalls.
//   Writes to $0 are accepted but never drive regWrite.
// Ports
//   clk, rst                 clock, async active-high reset
//   req0_valid/rd/data/ready ALU writeback handshake
//   req1_valid/rd/data/ready multi-cycle writeback handshake
//   rsv_valid, rsv_rd        destination reservation from issue logic
//   regWrite, rd, writeData  registered RegisterFile write port
//   busy_mask                registered pending-write bitmap
//
// state   | meaning
// PREFER0 | req0 wins contested cycles, req1 losses are counted
// FORCE1  | req1 wins if valid; otherwise req0 is served; then back to PREFER0
module regfile_write_scheduler #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_rd,
    input  logic [DATA_W-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_rd,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 req1_ready,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_rd,
    output logic                 regWrite,
    output logic [ADDR_W-1:0]    rd,
    output logic [DATA_W-1:0]    writeData,
    output logic [2**ADDR_W-1:0] busy_mask
);

    localparam int          NREG  = 2**ADDR_W;
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {PREFER0, FORCE1} state_t;

    state_t              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic                grant0, grant1, grant;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;
    logic                reg_write_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NREG-1:0]     busy_q, busy_d;

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            PREFER0: begin
                if (req0_valid) begin
                    grant0 = 1'b1;
                    // saturate rather than wrap
                    if (req1_valid && starve_q != 4'hF) starve_d = starve_q + 4'd1;
                end else if (req1_valid) begin
                    grant1   = 1'b1;
                    starve_d = 4'd0;
                end
                if (starve_d >= LIMIT) state_d = FORCE1;
            end
            FORCE1: begin
                if (req1_valid)      grant1 = 1'b1;
                else if (req0_valid) grant0 = 1'b1;
                starve_d = 4'd0;
                state_d  = PREFER0;
            end
            default: begin
                starve_d = 4'd0;
                state_d  = PREFER0;
            end
        endcase
    end

    assign grant      = grant0 | grant1;
    assign win_rd     = grant1 ? req1_rd   : req0_rd;
    assign win_data   = grant1 ? req1_data : req0_data;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Reservation is applied after the clear so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (grant && win_rd != '0)         busy_d[win_rd] = 1'b0;
        if (rsv_valid && rsv_rd != '0)     busy_d[rsv_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PREFER0;
            starve_q    <= 4'd0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            // $0 grants are accepted but leave the port idle and untouched
            reg_write_q <= grant && (win_rd != '0);
            if (grant && win_rd != '0) begin
                rd_q    <= win_rd;
                wdata_q <= win_data;
            end
        end
    end

    assign regWrite  = reg_write_q;
    assign rd        = rd_q;
    assign writeData = wdata_q;
    assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

    logic        clk, rst;
    logic        req0_valid, req1_valid, rsv_valid;
    logic [4:0]  req0_rd, req1_rd, rsv_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic [31:0] busy_mask;

    regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .regWrite(regWrite), .rd(rd), .writeData(writeData), .busy_mask(busy_mask)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] rf[32];
    int          checks = 0;
    int          errors = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // RegisterFile model plus scoreboard: every registered write must match
    // the oldest expected write, and is committed into the model.
    always @(negedge clk) begin
        if (!rst && regWrite) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: rd=%0d data=%0d with nothing expected", rd, writeData);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (rd !== e.rd || writeData !== e.data) begin
                    errors++;
                    $display("FAIL sb_write: got rd=%0d data=%0d, expected rd=%0d data=%0d",
                             rd, writeData, e.rd, e.data);
                end
            end
            rf[rd] = writeData;
        end
    end

    // One arbitration cycle: drive inputs, check readies, push expected write,
    // then advance past the grant edge. exp_g: 0/1 = requester granted, -1 = none.
    task automatic drive(input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input bit rv, input logic [4:0] rrd,
                         input int exp_g, input bit no_push, input string name);
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
        rsv_valid  = rv; rsv_rd  = rrd;
        #1;
        checks++;
        if (req0_ready !== 1'(exp_g == 0) || req1_ready !== 1'(exp_g == 1)) begin
            errors++;
            $display("FAIL %s: ready0=%b ready1=%b, expected grant to %0d", name, req0_ready, req1_ready, exp_g);
        end
        if (!no_push) begin
            if (exp_g == 0 && rd0 != 0) sb.push_back('{rd0, d0});
            if (exp_g == 1 && rd1 != 0) sb.push_back('{rd1, d1});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, "idle");
    endtask

    task automatic test_reset();
        #50;
        checks++;
        if (regWrite !== 1'b0 || rd !== 5'd0 || writeData !== 32'd0 || busy_mask !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: regWrite=%b rd=%0d wd=%0d busy=%h, expected all zero",
                     regWrite, rd, writeData, busy_mask);
        end
        #50 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        drive(1, 6, 12345, 0, 0, 0, 0, 0, 0, 0, "single_ready");
        req0_valid = 0;
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd6 || writeData !== 32'd12345) begin
            errors++;
            $display("FAIL single_port: regWrite=%b rd=%0d wd=%0d, expected 1/6/12345", regWrite, rd, writeData);
        end
        idle(1);
        checks++;
        if (rf[6] !== 32'd12345 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_commit: rf6=%0d regWrite=%b, expected 12345/0", rf[6], regWrite);
        end
    endtask

    task automatic test_back_to_back();
        int pattern[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [31:0] d1;
        d1 = 32'd5000;
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(10 + i), 32'(1000 + i), 1, 20, d1, 0, 0, pattern[i], 0, "b2b_grant");
            if (pattern[i] == 1) d1 = d1 + 1;
        end
        idle(2);
    endtask

    task automatic test_zero_filter();
        drive(0, 0, 0, 1, 0, 98765, 0, 0, 1, 0, "zero_ready");
        checks++;
        if (regWrite !== 1'b0 || busy_mask !== 32'd0) begin
            errors++;
            $display("FAIL zero_filter: regWrite=%b busy=%h, expected 0/0", regWrite, busy_mask);
        end
        idle(1);
        checks++;
        if (rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL zero_rf: rf0=%0d, expected 0", rf[0]);
        end
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 0, 0, 0, 1, 3, -1, 0, "rsv_only");
        checks++;
        if (busy_mask !== 32'h8) begin
            errors++;
            $display("FAIL busy_set: busy=%h, expected 00000008", busy_mask);
        end
        drive(0, 0, 0, 1, 3, 555, 1, 3, 1, 0, "rsv_collide");
        checks++;
        if (busy_mask !== 32'h8) begin
            errors++;
            $display("FAIL busy_set_wins: busy=%h, expected 00000008", busy_mask);
        end
        drive(1, 3, 777, 0, 0, 0, 0, 0, 0, 0, "busy_clear_wr");
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL busy_clear: busy=%h, expected 00000000", busy_mask);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            drive(1, 5'(11 + i), 32'(300 + i), 1, 21, 400, 0, 0, 0, 0, "rm_pre");
        drive(1, 7, 67890, 0, 0, 0, 1, 9, 0, 1, "rm_grant");
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd7 || busy_mask !== 32'h200) begin
            errors++;
            $display("FAIL rm_loaded: regWrite=%b rd=%0d busy=%h, expected 1/7/00000200", regWrite, rd, busy_mask);
        end
        #4 rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsv_valid = 0;
        #1;
        checks++;
        if (regWrite !== 1'b0 || busy_mask !== 32'd0) begin
            errors++;
            $display("FAIL rm_async: regWrite=%b busy=%h, expected 0/0", regWrite, busy_mask);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rf[7] !== 32'd0) begin
            errors++;
            $display("FAIL rm_dropped: rf7=%0d, expected 0", rf[7]);
        end
        // Counter must have restarted: four req0 wins before req1 is forced.
        for (int i = 0; i < 5; i++)
            drive(1, 5'(14 + i), 32'(500 + i), 1, 22, 600, 0, 0, (i == 4) ? 1 : 0, 0, "rm_rearb");
        idle(2);
    endtask

    task automatic test_req0_drop();
        for (int i = 0; i < 3; i++)
            drive(1, 5'(1 + i), 32'(700 + i), 1, 23, 800, 0, 0, 0, 0, "drop_pre");
        drive(0, 0, 0, 1, 23, 800, 0, 0, 1, 0, "drop_grant1");
        for (int i = 0; i < 5; i++)
            drive(1, 5'(4 + i), 32'(900 + i), 1, 24, 801, 0, 0, (i == 4) ? 1 : 0, 0, "drop_cnt_cleared");
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1;
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        rsv_valid  = 0; rsv_rd  = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_zero_filter();
        test_scoreboard();
        test_reset_mid();
        test_req0_drop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
